// File: rtl/pb_gpio_regs.sv
// PicoBlaze register block for pb_gpio: output enable/data, input readback and edge interrupts.
// Define PB_GPIO_REGS_SYNC_EN to pass gpio_data_o through a 2-flop synchronizer (+2 cycles latency).
module pb_gpio_regs #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] gpio_oe,
    output logic [7:0] gpio_enable,
    output logic [7:0] gpio_data_i,
    input  logic [7:0] gpio_data_o
);

    typedef enum logic [2:0] {
        OFF_OE         = 3'd0,
        OFF_ENABLE     = 3'd1,
        OFF_DATA_OUT   = 3'd2,
        OFF_DATA_IN    = 3'd3,
        OFF_INT_MASK   = 3'd4,
        OFF_INT_POL    = 3'd5,
        OFF_INT_STATUS = 3'd6,
        OFF_RSVD       = 3'd7
    } reg_off_e;

    logic       hit;
    reg_off_e   offset;
    logic       wr_en;

    logic [7:0] oe_q;
    logic [7:0] enable_q;
    logic [7:0] data_out_q;
    logic [7:0] int_mask_q;
    logic [7:0] int_pol_q;
    logic [7:0] int_status_q;
    logic [7:0] prev_q;

    logic [7:0] cur;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] event_bits;
    logic [7:0] w1c_bits;
    logic [7:0] rd_data;

    always_comb begin
        hit    = (port_id[7:3] == BASE_ADDR[7:3]);
        offset = reg_off_e'(port_id[2:0]);
        wr_en  = write_strobe & hit;
    end

`ifdef PB_GPIO_REGS_SYNC_EN
    logic [7:0] sync_q1;
    logic [7:0] sync_q2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= gpio_data_o;
            sync_q2 <= sync_q1;
        end
    end

    always_comb cur = sync_q2;
`else
    always_comb cur = gpio_data_o;
`endif

    // Output-enabled or disabled bits never raise events; polarity picks the edge per bit.
    always_comb begin
        rise       = cur & ~prev_q;
        fall       = ~cur & prev_q;
        event_bits = enable_q & ~oe_q & ((int_pol_q & rise) | (~int_pol_q & fall));
        w1c_bits   = (wr_en && offset == OFF_INT_STATUS) ? out_port : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oe_q       <= '0;
            enable_q   <= '0;
            data_out_q <= '0;
            int_mask_q <= '0;
            int_pol_q  <= '0;
        end else if (wr_en) begin
            case (offset)
                OFF_OE:       oe_q       <= out_port;
                OFF_ENABLE:   enable_q   <= out_port;
                OFF_DATA_OUT: data_out_q <= out_port;
                OFF_INT_MASK: int_mask_q <= out_port;
                OFF_INT_POL:  int_pol_q  <= out_port;
                default:      ;
            endcase
        end
    end

    // Set is ORed in after the clear so a coincident event wins over W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_status_q <= '0;
            prev_q       <= '0;
            interrupt    <= 1'b0;
        end else begin
            int_status_q <= (int_status_q & ~w1c_bits) | event_bits;
            prev_q       <= cur;
            interrupt    <= (|(int_status_q & int_mask_q)) & ~interrupt_ack;
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_OE:         rd_data = oe_q;
            OFF_ENABLE:     rd_data = enable_q;
            OFF_DATA_OUT:   rd_data = data_out_q;
            OFF_DATA_IN:    rd_data = cur;
            OFF_INT_MASK:   rd_data = int_mask_q;
            OFF_INT_POL:    rd_data = int_pol_q;
            OFF_INT_STATUS: rd_data = int_status_q;
            OFF_RSVD:       rd_data = '0;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_port <= '0;
        end else begin
            in_port <= hit ? rd_data : '0;
        end
    end

    assign gpio_oe     = oe_q;
    assign gpio_enable = enable_q;
    assign gpio_data_i = data_out_q;

endmodule

// File: doc/pb_gpio_regs.md
PB_GPIO_REGS -- requirements
Module: pb_gpio_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00, meaning PicoBlaze port base (8-aligned; bits [2:0] ignored).
REQ-002 SHALL have ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- port_id  in  8  PicoBlaze port address.
- write_strobe  in  1  PicoBlaze write qualifier.
- out_port  in  8  PicoBlaze write data.
- in_port  out  8  PicoBlaze read data, registered.
- interrupt  out  1  PicoBlaze interrupt request.
- interrupt_ack  in  1  PicoBlaze interrupt acknowledge.
- gpio_oe  out  8  per-bit output enable to pb_gpio.
- gpio_enable  out  8  per-bit enable to pb_gpio.
- gpio_data_i  out  8  output data to pb_gpio.
- gpio_data_o  in  8  registered pin data from pb_gpio.

Function
REQ-003 SHALL decode a hit when port_id[7:3]==BASE_ADDR[7:3]; offset = port_id[2:0].
REQ-004 SHALL implement the map: 0 OE (RW), 1 ENABLE (RW), 2 DATA_OUT (RW), 3 DATA_IN (RO), 4 INT_MASK (RW), 5 INT_POL (RW, 1=rising, 0=falling), 6 INT_STATUS (R/W1C), 7 reserved (reads 8'h00).
REQ-005 SHALL update an RW register at the clock edge where write_strobe=1 and the hit addresses it; writes to offsets 3, 7 or non-hit ports are ignored.
REQ-006 SHALL drive gpio_oe, gpio_enable and gpio_data_i directly from OE, ENABLE and DATA_OUT registers (zero added latency).
REQ-007 SHALL register in_port every cycle from the current port_id decode: data for port_id at cycle N appears at cycle N+1; non-hit ports give 8'h00.
REQ-008 SHALL return gpio_data_o (after optional sync, REQ-016) for DATA_IN reads.
REQ-009 SHALL keep prev[7:0] = last sampled input every cycle, regardless of enable.
REQ-010 SHALL detect per-bit events: rise = cur & ~prev, fall = ~cur & prev; event = ENABLE & ~OE & (INT_POL ? rise : fall).
REQ-011 SHALL set INT_STATUS[b] the cycle after event[b]; status is sticky until W1C.
REQ-012 SHALL clear INT_STATUS bits written with 1 at offset 6; when set and clear hit the same bit in the same cycle, set wins.
REQ-013 SHALL register interrupt <= |(INT_STATUS & INT_MASK) & ~interrupt_ack; after ack it re-asserts the next cycle if masked status remains.
REQ-014 SHALL treat enabling an input that is high as a rising event (pb_gpio drives 0 for disabled bits); firmware clears INT_STATUS after changing ENABLE.

Reset
REQ-015 SHALL, while rst_i=1 at a clock edge, set OE, ENABLE, DATA_OUT, INT_MASK, INT_POL, INT_STATUS, prev, sync stages, in_port and interrupt to 0; reset mid-write discards the write.

Configuration
REQ-016 SHALL, with PB_GPIO_REGS_SYNC_EN defined, pass gpio_data_o through a 2-flop synchronizer before DATA_IN and edge detection (+2 cycles event/readback latency); without it, gpio_data_o is used directly.

Verification
REQ-017 Write 8'h0F to BASE+1, then read BASE+1 -> in_port=8'h0F one cycle after port_id presented; gpio_enable=8'h0F.
REQ-018 ENABLE=8'h01, OE=0, INT_POL=8'h01, INT_MASK=8'h01; gpio_data_o[0] 0->1 -> INT_STATUS=8'h01 next cycle, interrupt=1 the cycle after.
REQ-019 Assert interrupt_ack with status pending -> interrupt=0 for one cycle, then 1; write 8'h01 to BASE+6 -> interrupt=0 and stays 0.
REQ-020 Edge on bit 2 in the same cycle as W1C of 8'h04 -> INT_STATUS[2] remains 1.
REQ-021 OE=8'h01, ENABLE=8'h01, toggle gpio_data_o[0] -> no status; write 8'hAA to BASE+3 and BASE+7 -> no register change, reads 8'h00 at BASE+7.
REQ-022 rst_i pulsed with all registers at 8'hFF and interrupt=1 -> all outputs 8'h00/0 next cycle.
